// File: rtl/muldiv_if.sv
// Execution-stage <-> multiply/divide unit bus.
// master (execution stage): drives start/op/a/b/cancel, observes busy/done/hi/lo.
// slave  (muldiv_unit): the reverse.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Ports: clk, reset (sync, active-high), bus (muldiv_if.slave):
//   start/op/a/b/cancel in; busy, done (1-cycle pulse), hi, lo out (all registered).
// op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
module muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int unsigned CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             busyReg, busyNext;
    logic             doneReg, doneNext;
    logic [WIDTH-1:0] hiReg, hiNext;
    logic [WIDTH-1:0] loReg, loNext;
    logic [WIDTH-1:0] aReg, aNext;
    logic [WIDTH-1:0] bReg, bNext;
    logic             signedReg, signedNext;
    logic [WIDTH-1:0] remReg, remNext;
    logic [WIDTH-1:0] quoReg, quoNext;
    logic [WIDTH-1:0] divisorReg, divisorNext;
    logic             negQReg, negQNext;
    logic             negRReg, negRNext;
    logic             divZeroReg, divZeroNext;

    // Multiply datapath: operands widened to 2*WIDTH so one multiplier serves both signednesses.
    logic [2*WIDTH-1:0] extA, extB, product;
    assign extA    = signedReg ? {{WIDTH{aReg[WIDTH-1]}}, aReg} : {{WIDTH{1'b0}}, aReg};
    assign extB    = signedReg ? {{WIDTH{bReg[WIDTH-1]}}, bReg} : {{WIDTH{1'b0}}, bReg};
    assign product = extA * extB;

    // One restoring-division step on magnitudes; quotient bits shift in from the right.
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] remStep, quoStep;
    always_comb begin
        shifted = {remReg, quoReg[WIDTH-1]};
        diff    = shifted - {1'b0, divisorReg};
        remStep = shifted[WIDTH-1:0];
        quoStep = {quoReg[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            remStep = diff[WIDTH-1:0];
            quoStep = {quoReg[WIDTH-2:0], 1'b1};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
            hiReg      <= '0;
            loReg      <= '0;
            aReg       <= '0;
            bReg       <= '0;
            signedReg  <= 1'b0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            negQReg    <= 1'b0;
            negRReg    <= 1'b0;
            divZeroReg <= 1'b0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            busyReg    <= busyNext;
            doneReg    <= doneNext;
            hiReg      <= hiNext;
            loReg      <= loNext;
            aReg       <= aNext;
            bReg       <= bNext;
            signedReg  <= signedNext;
            remReg     <= remNext;
            quoReg     <= quoNext;
            divisorReg <= divisorNext;
            negQReg    <= negQNext;
            negRReg    <= negRNext;
            divZeroReg <= divZeroNext;
        end
    end

    // Next-state and output logic.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        busyNext    = busyReg;
        doneNext    = 1'b0;
        hiNext      = hiReg;
        loNext      = loReg;
        aNext       = aReg;
        bNext       = bReg;
        signedNext  = signedReg;
        remNext     = remReg;
        quoNext     = quoReg;
        divisorNext = divisorReg;
        negQNext    = negQReg;
        negRNext    = negRReg;
        divZeroNext = divZeroReg;

        unique case (state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            aNext      = bus.a;
                            bNext      = bus.b;
                            signedNext = (bus.op == OP_MULT) || (bus.op == OP_DIV);
                            busyNext   = 1'b1;
                            if ((bus.op == OP_MULT) || (bus.op == OP_MULTU)) begin
                                stateNext = MUL;
                                cntNext   = CNT_W'(MUL_CYCLES - 1);
                            end else begin
                                stateNext = DIV;
                                cntNext   = CNT_W'(WIDTH);
                            end
                        end
                        OP_MTHI: hiNext = bus.a;
                        OP_MTLO: loNext = bus.a;
                        default: ;
                    endcase
                end
            end

            MUL: begin
                if (bus.cancel) begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                end else if (cnt == '0) begin
                    hiNext    = product[2*WIDTH-1:WIDTH];
                    loNext    = product[WIDTH-1:0];
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end

            DIV: begin
                if (bus.cancel) begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                end else if (cnt == CNT_W'(WIDTH)) begin
                    // Setup cycle: take magnitudes and remember the result signs.
                    quoNext     = (signedReg && aReg[WIDTH-1]) ? (WIDTH'(0) - aReg) : aReg;
                    divisorNext = (signedReg && bReg[WIDTH-1]) ? (WIDTH'(0) - bReg) : bReg;
                    remNext     = '0;
                    negQNext    = signedReg && (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
                    negRNext    = signedReg && aReg[WIDTH-1];
                    divZeroNext = (bReg == '0);
                    cntNext     = cnt - 1'b1;
                end else begin
                    remNext = remStep;
                    quoNext = quoStep;
                    if (cnt == '0) begin
                        // Last iteration: apply signs; divide-by-zero overrides the result.
                        if (divZeroReg) begin
                            loNext = '1;
                            hiNext = aReg;
                        end else begin
                            loNext = negQReg ? (WIDTH'(0) - quoStep) : quoStep;
                            hiNext = negRReg ? (WIDTH'(0) - remStep) : remStep;
                        end
                        doneNext  = 1'b1;
                        stateNext = IDLE;
                        busyNext  = 1'b0;
                    end else begin
                        cntNext = cnt - 1'b1;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

    assign bus.busy = busyReg;
    assign bus.done = doneReg;
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;
endmodule
